apb_completer_regfile: RTL
==========================

# apb_completer_regfile

APB completer (slave) that backs one PSELx line of the APB requester with a bank of byte-strobed read/write registers. It accepts the standard two-phase transfer (setup, then access) and inserts a programmable number of wait states before asserting PREADY. Out-of-range, misaligned and malformed accesses are flagged with PSLVERR. It is instantiated once per peripheral slot on the APB bus, behind the requester's PSELx decode.

## Interface
- DataWidth, 32, PWDATA/PRDATA width; must be a multiple of 8
- AddrWidth, 32, PADDR width
- Depth, 16, number of DataWidth-bit registers; power of two, minimum 2
- WaitCycles, 2, wait states per access (range 0..15); used only when wait insertion is compiled in
- PCLK  input  1  bus clock; all state changes on its rising edge
- PRESETn  input  1  asynchronous, active-low reset
- PSEL  input  1  this completer's select line (one PSELx bit)
- PENABLE  input  1  access-phase indicator
- PWRITE  input  1  1 = write, 0 = read
- PADDR  input  AddrWidth  byte address
- PWDATA  input  DataWidth  write data
- PSTRB  input  DataWidth/8  byte-lane write strobes
- PREADY  output  1  transfer complete in this access cycle
- PRDATA  output  DataWidth  read data, valid when PREADY=1 on a read
- PSLVERR  output  1  error response, valid only when PREADY=1

## Operation
- Local definitions: SB = log2(DataWidth/8), the byte-offset bits; idx = PADDR[SB +: log2(Depth)].
- Reset (PRESETn=0, asynchronous) forces state IDLE, wait counter 0, all registers 0, PRDATA 0, PREADY 0 and PSLVERR 0.
- **IDLE** state:
  - PSEL=1 and PENABLE=0 (setup phase): capture PWRITE, idx, PWDATA and PSTRB, plus an error flag. The flag is set if PADDR[SB-1:0]≠0 or PADDR ≥ Depth·DataWidth/8. Load counter = WaitCycles, then go to ACCESS.
  - PSEL=1 and PENABLE=1 with no prior setup (protocol violation): PREADY=1 and PSLVERR=1 in the same cycle (combinational). No register is modified. Stay in IDLE.
  - Otherwise remain in IDLE.
- **ACCESS** state:
  - PSEL=0: abort to IDLE. No write occurs and no response is given.
  - PSEL=1, PENABLE=1, counter≠0: PREADY=0, decrement counter.
  - PSEL=1, PENABLE=1, counter=0: PREADY=1, PSLVERR = error flag, go to IDLE. If the transfer is a write and the flag is clear, update byte lane i of reg[idx] from the captured PWDATA only where PSTRB[i]=1.
  - PSEL=1, PENABLE=0: hold the counter; PREADY stays 0.
- PREADY and PSLVERR are combinational from the state and counter. Outside the ready cycle both are 0.
- PRDATA is a register loaded at the setup edge:
  - read with error flag clear: reg[idx]
  - write, or error flag set: 0
  - PRDATA holds until the next setup.
- PSTRB=0 on a write: no register changes, PSLVERR=0.
- Reads ignore PSTRB.
- Captured PWDATA is used, not live PWDATA, so the requester may change the bus after setup without effect.

## Timing
- Setup at cycle T0; access begins at T1.
- PREADY=1 in cycle T1+WaitCycles, giving WaitCycles+1 access cycles.
- A write is visible in the register at the PCLK edge that ends the ready cycle.
- A read of the same index in the next transfer returns the new value.
- Back-to-back: a setup phase in the cycle immediately after PREADY is accepted, so there are no dead cycles.
- Reset asserted mid-transfer aborts the transfer immediately. After PRESETn deasserts, the block is in IDLE.
- Counter width is 4 bits.

## Configuration
- APB_COMPLETER_WAIT_EN defined: the wait counter is implemented and WaitCycles applies.
- APB_COMPLETER_WAIT_EN undefined:
  - counter logic is removed and WaitCycles is ignored
  - PREADY=1 in the first access cycle (T1), i.e. zero-wait
  - all other behaviour, including errors and the protocol-violation response, is identical.

## Test plan
- Full-strobe write, then read back (WaitCycles=2): write 0xDEADBEEF to PADDR 0x08 with PSTRB=0xF, then read 0x08. Each transfer gets PREADY at T3 and PSLVERR=0; the read returns PRDATA=0xDEADBEEF.
- Partial-strobe write: reg[3] is 0x11223344; write 0xAABBCCDD with PSTRB=0x5. Readback gives 0x11BB33DD.
- Error responses:
  - Out-of-range: write 0x12345678 to PADDR 0x40 (Depth=16) → PREADY=1, PSLVERR=1; all registers unchanged.
  - Misaligned: read 0x02 → PSLVERR=1, PRDATA=0.
- Protocol violations:
  - PSEL=1, PENABLE=1 asserted from IDLE → PREADY=1, PSLVERR=1 in that same cycle, and no write occurs.
  - PSEL dropped mid-wait → no write; a following legal read of that register returns its old value.
- Reset and back-to-back:
  - PRESETn pulsed low during a write's wait → all registers 0, PREADY 0, the write is lost.
  - Two back-to-back writes (setup immediately after PREADY) both complete.
  - With APB_COMPLETER_WAIT_EN undefined, PREADY asserts at T1.

Source files
------------

// File: rtl/apb_completer_regfile_if.sv
// APB bus bundle between one requester PSELx slot and an apb_completer_regfile.
// The master side drives select/enable/address/data; the slave side answers.
interface apb_completer_regfile_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32
);
    logic                   PSEL;
    logic                   PENABLE;
    logic                   PWRITE;
    logic [AddrWidth-1:0]   PADDR;
    logic [DataWidth-1:0]   PWDATA;
    logic [DataWidth/8-1:0] PSTRB;
    logic                   PREADY;
    logic [DataWidth-1:0]   PRDATA;
    logic                   PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_completer_regfile.sv
// APB completer backed by a byte-strobed register bank, with PSLVERR on bad accesses.
// Define APB_COMPLETER_WAIT_EN to insert WaitCycles wait states per access.
module apb_completer_regfile #(
    parameter int DataWidth  = 32,
    parameter int AddrWidth  = 32,
    parameter int Depth      = 16,
    parameter int WaitCycles = 2
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    apb_completer_regfile_if.slave apb
);
    localparam int BYTES = DataWidth / 8;
    localparam int SB    = $clog2(BYTES);
    localparam int IW    = $clog2(Depth);
    localparam logic [AddrWidth:0] LIMIT = (AddrWidth + 1)'(Depth * BYTES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t               state_reg, state_next;
    logic                 wr_reg;
    logic [IW-1:0]        idx_reg;
    logic [DataWidth-1:0] wdata_reg;
    logic [BYTES-1:0]     strb_reg;
    logic                 err_reg;
    logic [DataWidth-1:0] prdata_reg;
    logic [DataWidth-1:0] reg_q [Depth];

    logic                 setup;
    logic                 do_write;
    logic                 cnt_zero;
    logic                 pready;
    logic                 pslverr;
    logic                 misaligned;
    logic                 err_next;
    logic [IW-1:0]        idx_next;

    generate
        if (SB > 0) begin : g_align
            assign misaligned = |apb.PADDR[SB-1:0];
        end else begin : g_noalign
            assign misaligned = 1'b0;
        end
    endgenerate

    assign err_next = misaligned || ({1'b0, apb.PADDR} >= LIMIT);
    assign idx_next = apb.PADDR[SB +: IW];

`ifdef APB_COMPLETER_WAIT_EN
    localparam logic [3:0] WAIT_INIT = 4'(WaitCycles);
    logic [3:0] cnt_reg, cnt_next;

    assign cnt_zero = (cnt_reg == 4'd0);

    // Counter only moves on genuine access cycles; a PENABLE=0 gap holds it.
    always_comb begin
        cnt_next = cnt_reg;
        if (setup) begin
            cnt_next = WAIT_INIT;
        end else if (state_reg == ACCESS && apb.PSEL && apb.PENABLE && !cnt_zero) begin
            cnt_next = cnt_reg - 4'd1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end
`else
    assign cnt_zero = 1'b1;
`endif

    always_comb begin
        state_next = state_reg;
        setup      = 1'b0;
        do_write   = 1'b0;
        pready     = 1'b0;
        pslverr    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (apb.PSEL && !apb.PENABLE) begin
                    setup      = 1'b1;
                    state_next = ACCESS;
                end else if (apb.PSEL && apb.PENABLE) begin
                    // Access phase with no setup: answer with an error at once.
                    pready  = 1'b1;
                    pslverr = 1'b1;
                end
            end
            ACCESS: begin
                if (!apb.PSEL) begin
                    state_next = IDLE;
                end else if (apb.PENABLE && cnt_zero) begin
                    pready     = 1'b1;
                    pslverr    = err_reg;
                    do_write   = wr_reg && !err_reg;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Everything the access needs is latched at setup so the bus may change afterwards.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_reg     <= 1'b0;
            idx_reg    <= '0;
            wdata_reg  <= '0;
            strb_reg   <= '0;
            err_reg    <= 1'b0;
            prdata_reg <= '0;
        end else if (setup) begin
            wr_reg     <= apb.PWRITE;
            idx_reg    <= idx_next;
            wdata_reg  <= apb.PWDATA;
            strb_reg   <= apb.PSTRB;
            err_reg    <= err_next;
            prdata_reg <= (!apb.PWRITE && !err_next) ? reg_q[idx_next] : '0;
        end
    end

    generate
        for (genvar gi = 0; gi < Depth; gi++) begin : g_reg
            logic [DataWidth-1:0] q_reg;

            always_ff @(posedge PCLK or negedge PRESETn) begin
                if (!PRESETn) begin
                    q_reg <= '0;
                end else if (do_write && idx_reg == IW'(gi)) begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (strb_reg[b]) begin
                            q_reg[8*b +: 8] <= wdata_reg[8*b +: 8];
                        end
                    end
                end
            end

            assign reg_q[gi] = q_reg;
        end
    endgenerate

    assign apb.PREADY  = pready;
    assign apb.PSLVERR = pslverr;
    assign apb.PRDATA  = prdata_reg;
endmodule
